// File: rtl/sp_ram_clr.sv
// Single-port RAM with per-byte write mask, selectable read-during-write
// behaviour, optional output register and a sequential whole-array clear.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | user port owns the array; CLR=1 at an edge starts a clear
// CLEAR  | sequencer writes zero to word CNT each edge; user port dropped
module sp_ram_clr #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 0,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int NB        = DATA_WIDTH / 8
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  CEN,
   input  logic                  WEN,
   input  logic [NB-1:0]         BWEN,
   input  logic [AW-1:0]         A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  CLR,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  QV,
   output logic                  BUSY
);

   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [AW-1:0]         r_cnt;
   logic [AW-1:0]         w_cnt_nxt;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   logic                  w_in_range;
   logic                  w_acc;
   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_q_nxt;
   logic                  w_q_upd;

   assign BUSY       = (r_state == ST_CLEAR);
   assign w_in_range = ({1'b0, A} < DEPTH_W);
   assign w_acc      = !CEN && !BUSY;
   assign w_wr       = w_acc && !WEN && w_in_range;
   // Out-of-range addresses read as zero rather than aliasing onto real words.
   assign w_rd_word  = w_in_range ? r_mem[A] : '0;

   // Clear-sequencer state and word counter; reset starts a full clear.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: CLR is only honoured from IDLE, so a clear never restarts itself.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (CLR) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            if (r_cnt == LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Byte-masked merge of write data over the stored word.
   always_comb begin
      w_merged = w_rd_word;
      for (int i = 0; i < NB; i++) begin
         if (!BWEN[i]) w_merged[8*i +: 8] = D[8*i +: 8];
      end
      if (!w_in_range) w_merged = '0;
   end

   // Read data selection per read-during-write mode; no-change mode skips writes.
   always_comb begin
      w_q_nxt = w_rd_word;
      if (!WEN && (WRITE_MODE == 0)) w_q_nxt = w_merged;
      w_q_upd = w_acc && (WEN || (WRITE_MODE != 2));
   end

   // Array storage: clear writes and user writes are mutually exclusive via BUSY.
   always_ff @(posedge CLK) begin
      if (BUSY)      r_mem[r_cnt] <= '0;
      else if (w_wr) r_mem[A]     <= w_merged;
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] r_p_q;
         logic                  r_p_v;

         // Two-stage output: capture at the access edge, present one edge later.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               r_p_q <= '0;
               r_p_v <= 1'b0;
               Q     <= '0;
               QV    <= 1'b0;
            end else begin
               r_p_v <= w_q_upd;
               if (w_q_upd) r_p_q <= w_q_nxt;
               QV    <= r_p_v;
               if (r_p_v)   Q     <= r_p_q;
            end
         end
      end else begin : g_no_out_reg
         // Single-stage output: Q and QV update at the access edge.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               Q  <= '0;
               QV <= 1'b0;
            end else begin
               QV <= w_q_upd;
               if (w_q_upd) Q <= w_q_nxt;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sp_ram_clr.sv
// Directed bench for sp_ram_clr: several instances with different parameter
// sets share one stimulus stream; the DEPTH=5 instance has its own reset/clear.
module tb_sp_ram_clr;

   logic        CLK;
   logic        RSTN;
   logic        rstn4;
   logic        CEN;
   logic        WEN;
   logic [3:0]  BWEN;
   logic [9:0]  A;
   logic [31:0] D;
   logic        CLR;
   logic        clr4;

   logic [31:0] q0, q1, q2, q3, q4;
   logic        qv0, qv1, qv2, qv3, qv4;
   logic        busy0, busy1, busy2, busy3, busy4;

   int checks   = 0;
   int failures = 0;
   int n;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   sp_ram_clr u0 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D),
      .CLR(CLR), .Q(q0), .QV(qv0), .BUSY(busy0));

   sp_ram_clr #(.DEPTH(16), .WRITE_MODE(1)) u1 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A[3:0]), .D(D),
      .CLR(CLR), .Q(q1), .QV(qv1), .BUSY(busy1));

   sp_ram_clr #(.DEPTH(16), .WRITE_MODE(2)) u2 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A[3:0]), .D(D),
      .CLR(CLR), .Q(q2), .QV(qv2), .BUSY(busy2));

   sp_ram_clr #(.DEPTH(16), .OUT_REG(1)) u3 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A[3:0]), .D(D),
      .CLR(CLR), .Q(q3), .QV(qv3), .BUSY(busy3));

   sp_ram_clr #(.DEPTH(5)) u4 (
      .CLK(CLK), .RSTN(rstn4), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A[2:0]), .D(D),
      .CLR(clr4), .Q(q4), .QV(qv4), .BUSY(busy4));

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One access on the next edge, then release the port.
   task automatic acc(input logic wen, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] bwen);
      CEN  = 1'b0;
      WEN  = wen;
      A    = a;
      D    = d;
      BWEN = bwen;
      step();
      CEN  = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      RSTN = 1'b0; rstn4 = 1'b0; CEN = 1'b1; WEN = 1'b1; A = '0; D = '0;
      BWEN = 4'hF; CLR = 1'b0; clr4 = 1'b0;
      repeat (3) step();
      chk("rst_busy", 32'(busy0), 32'd1);
      chk("rst_q", q0, 32'h0);
      chk("rst_qv", 32'(qv0), 32'd0);
      chk("rst_q_outreg", q3, 32'h0);
      chk("rst_busy_d5", 32'(busy4), 32'd1);

      RSTN = 1'b1; rstn4 = 1'b1;
      n = 0;
      while (busy0 && n < 2000) begin step(); n++; end
      chk("rst_clear_len", 32'(n), 32'd1024);
      chk("post_clear_q", q0, 32'h0);

      acc(1'b1, 10'd5, 32'h0, 4'hF);
      chk("rd5_q", q0, 32'h0);
      chk("rd5_qv", 32'(qv0), 32'd1);
      step();
      chk("idle_qv", 32'(qv0), 32'd0);

      acc(1'b0, 10'd3, 32'hAABBCCDD, 4'b1010);
      chk("bw_wr_q_mode0", q0, 32'h00BB00DD);
      acc(1'b1, 10'd3, 32'h0, 4'hF);
      chk("bw_rd_q", q0, 32'h00BB00DD);
      chk("bw_rd_qv", 32'(qv0), 32'd1);
      chk("bw_rd_q_m1", q1, 32'h00BB00DD);

      acc(1'b0, 10'd7, 32'h11111111, 4'h0);
      step();
      acc(1'b0, 10'd7, 32'h22222222, 4'h0);
      chk("rdw_mode0_q", q0, 32'h22222222);
      chk("rdw_mode1_q", q1, 32'h11111111);
      chk("rdw_mode1_qv", 32'(qv1), 32'd1);
      chk("rdw_mode2_q", q2, 32'h00BB00DD);
      chk("rdw_mode2_qv", 32'(qv2), 32'd0);

      acc(1'b0, 10'd1, 32'h00000001, 4'h0);
      acc(1'b0, 10'd2, 32'h00000002, 4'h0);
      step();
      step();
      chk("or_drained_qv", 32'(qv3), 32'd0);
      CEN = 1'b0; WEN = 1'b1; A = 10'd1;
      step();
      chk("or_e1_qv", 32'(qv3), 32'd0);
      A = 10'd2;
      step();
      chk("or_e2_qv", 32'(qv3), 32'd1);
      chk("or_e2_q", q3, 32'h00000001);
      A = 10'd3;
      step();
      chk("or_e3_qv", 32'(qv3), 32'd1);
      chk("or_e3_q", q3, 32'h00000002);
      CEN = 1'b1;
      step();
      chk("or_e4_qv", 32'(qv3), 32'd1);
      chk("or_e4_q", q3, 32'h00BB00DD);
      step();
      chk("or_e5_qv", 32'(qv3), 32'd0);
      chk("or_e5_q", q3, 32'h00BB00DD);

      CLR = 1'b1;
      acc(1'b0, 10'd9, 32'h00000099, 4'h0);
      CLR = 1'b0;
      chk("clr_busy", 32'(busy0), 32'd1);
      chk("clr_same_edge_q", q0, 32'h00000099);
      chk("clr_same_edge_qv", 32'(qv0), 32'd1);
      acc(1'b0, 10'd10, 32'h000000AA, 4'h0);
      chk("busy_wr_q", q0, 32'h00000099);
      chk("busy_wr_qv", 32'(qv0), 32'd0);
      n = 1;
      while (busy0 && n < 2000) begin
         CLR = (n == 100);
         step();
         n++;
      end
      CLR = 1'b0;
      chk("clr_len_no_restart", 32'(n), 32'd1024);
      acc(1'b1, 10'd9, 32'h0, 4'hF);
      chk("clr_rd9_q", q0, 32'h0);
      chk("clr_rd9_qv", 32'(qv0), 32'd1);
      acc(1'b1, 10'd10, 32'h0, 4'hF);
      chk("clr_rd10_q", q0, 32'h0);
      acc(1'b1, 10'd7, 32'h0, 4'hF);
      chk("clr_rd7_q", q0, 32'h0);
      acc(1'b1, 10'd3, 32'h0, 4'hF);
      chk("clr_rd3_q", q0, 32'h0);

      acc(1'b0, 10'd2, 32'h00000055, 4'h0);
      chk("d5_wr_q", q4, 32'h00000055);
      acc(1'b1, 10'd6, 32'h0, 4'hF);
      chk("d5_oob_q", q4, 32'h0);
      chk("d5_oob_qv", 32'(qv4), 32'd1);
      acc(1'b0, 10'd4, 32'h00000044, 4'h0);
      acc(1'b1, 10'd4, 32'h0, 4'hF);
      chk("d5_rd4_q", q4, 32'h00000044);

      clr4 = 1'b1;
      step();
      clr4 = 1'b0;
      chk("d5_clr_busy", 32'(busy4), 32'd1);
      repeat (3) step();
      rstn4 = 1'b0;
      #1;
      chk("d5_midrst_busy", 32'(busy4), 32'd1);
      chk("d5_midrst_q", q4, 32'h0);
      chk("d5_midrst_qv", 32'(qv4), 32'd0);
      step();
      rstn4 = 1'b1;
      n = 0;
      while (busy4 && n < 100) begin step(); n++; end
      chk("d5_restart_len", 32'(n), 32'd5);
      acc(1'b0, 10'd1, 32'h00000077, 4'h0);
      chk("d5_post_wr_q", q4, 32'h00000077);
      acc(1'b1, 10'd4, 32'h0, 4'hF);
      chk("d5_full_clear_q", q4, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sp_ram_clr.md
SP_RAM_CLR -- requirements
Module: sp_ram_clr

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, data word width; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL take parameter DEPTH, default 1024, number of words; it SHALL be at least 2.
REQ-003 The block SHALL take parameter WRITE_MODE, default 0, read-during-write behaviour: 0 write-first, 1 read-first, 2 no-change.
REQ-004 The block SHALL take parameter OUT_REG, default 0, extra output pipeline stage: 0 off, 1 on.
REQ-005 The block SHALL derive localparams AW = ceil(log2(DEPTH)) and NB = DATA_WIDTH/8.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port RSTN, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port CEN, input, 1 bit: chip enable, active-low.
REQ-009 The block SHALL have port WEN, input, 1 bit: write enable, active-low; high means read.
REQ-010 The block SHALL have port BWEN, input, NB bits: per-byte write mask, active-low; bit i covers D[8i+7:8i].
REQ-011 The block SHALL have port A, input, AW bits: word address.
REQ-012 The block SHALL have port D, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL have port CLR, input, 1 bit: active-high request to zero the whole array.
REQ-014 The block SHALL have port Q, output, DATA_WIDTH bits: read data.
REQ-015 The block SHALL have port QV, output, 1 bit: one-cycle pulse marking the cycle Q is updated by an access.
REQ-016 The block SHALL have port BUSY, output, 1 bit: high while the clear sequencer owns the array.

Function
REQ-017 An access SHALL occur on a rising CLK edge where CEN=0 and BUSY=0; all other edges are idle for the user port.
REQ-018 On a write access (WEN=0), each byte i with BWEN[i]=0 SHALL be written from D; bytes with BWEN[i]=1 SHALL keep their stored value.
REQ-019 On a read access (WEN=1), the word at A SHALL be read; the array SHALL be unchanged.
REQ-020 On a write access, Q SHALL follow WRITE_MODE: mode 0 gives the merged post-write word, mode 1 gives the pre-write word, mode 2 holds Q and does not pulse QV.
REQ-021 With OUT_REG=0, Q and QV SHALL update at the access edge (1-cycle latency); with OUT_REG=1, at the following edge (2-cycle latency), fully pipelined.
REQ-022 With no access, Q SHALL hold its last value and QV SHALL be 0 (OUT_REG=1 still drains the pipeline stage).
REQ-023 An address A >= DEPTH (non-power-of-2 DEPTH) SHALL not write; a read there SHALL return all zeros with QV pulsed.
REQ-024 The clear FSM SHALL have states IDLE and CLEAR, with an AW-bit counter CNT.
REQ-025 IDLE SHALL move to CLEAR when CLR=1 at an edge, setting CNT=0; an access on that same edge SHALL still complete.
REQ-026 In CLEAR, each edge SHALL write zero to word CNT and increment CNT; after writing word DEPTH-1, the FSM SHALL return to IDLE, taking DEPTH cycles in total.
REQ-027 BUSY SHALL be 1 exactly while the state is CLEAR; CLR in CLEAR SHALL be ignored, with no restart.
REQ-028 User accesses while BUSY=1 SHALL be dropped: no write, no Q/QV change, no error.

Reset
REQ-029 RSTN=0 SHALL asynchronously force state CLEAR, CNT=0, BUSY=1, Q=0, QV=0 and the OUT_REG pipeline to 0.
REQ-030 After RSTN rises, the array SHALL be cleared automatically over DEPTH cycles before BUSY falls.
REQ-031 RSTN asserted mid-clear SHALL restart the clear from CNT=0.
REQ-032 The array SHALL have no reset of its own; it is only zeroed by the clear FSM.

Verification
REQ-033 Defaults, release reset -> BUSY high exactly 1024 cycles, Q=0; then a read of A=5 -> Q=0, QV=1 one cycle later.
REQ-034 Write D=0xAABBCCDD, BWEN=4'b1010 to A=3, then read A=3 -> Q=0x00BB00DD.
REQ-035 A=7 holds 0x11111111, write 0x22222222 with full mask -> Q=0x22222222 for WRITE_MODE=0, 0x11111111 for 1, and unchanged Q with QV=0 for 2.
REQ-036 OUT_REG=1, back-to-back reads of A=1,2,3 -> QV high on 3 consecutive cycles starting 2 edges after the first read, data in order.
REQ-037 Fill words, pulse CLR with a simultaneous write, then write during BUSY -> the simultaneous write lands, the BUSY write is dropped, all words read 0 after DEPTH cycles.
REQ-038 DEPTH=5, read A=6 -> Q=0, QV=1; assert RSTN at CNT=3 of a CLR -> clear restarts, BUSY high 5 more cycles after release.
